// File: rtl/axi_slave_mem.sv
// ---------------------------------------------------------------------------
// axi_slave_mem
//   AXI4 slave backed by a word-addressed on-chip memory. The write and read
//   channels run independently, each with one burst in flight. FIXED, INCR
//   and WRAP bursts are supported; the reserved burst type behaves as INCR.
//   Every AXI output comes straight from a flop. The memory array itself is
//   not reset.
//
// Ports
//   clk, reset                 clock, synchronous active-low reset
//   aw* / awvalid / awready    write address command
//   wdata/wstrb/wlast/wvalid   write data beats, wready back
//   bid/bresp/bvalid/bready    write response
//   ar* / arvalid / arready    read address command
//   rid/rdata/rresp/rlast      read data beats with rvalid/rready
//   awlock/awcache/awprot,
//   arlock/arcache/arprot      accepted and ignored
//
// State table
//   W_IDLE | waiting for a write command (awready=1)
//   W_DATA | accepting write beats (wready=1)
//   W_RESP | presenting the write response (bvalid=1)
//   R_IDLE | waiting for a read command (arready=1)
//   R_DATA | presenting read beats (rvalid=1)
// ---------------------------------------------------------------------------
module axi_slave_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 8,
    parameter int MEM_WORDS  = 1024
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    awlock,
    input  logic [3:0]              awcache,
    input  logic [2:0]              awprot,
    input  logic                    awvalid,
    output logic                    awready,

    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,

    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,

    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic                    arlock,
    input  logic [3:0]              arcache,
    input  logic [2:0]              arprot,
    input  logic                    arvalid,
    output logic                    arready,

    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);

    localparam int IDX_W  = $clog2(MEM_WORDS);
    localparam int STRB_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    logic unused_sideband;
    assign unused_sideband = ^{awlock, awcache, awprot, arlock, arcache, arprot};

    // Address of the following beat. WRAP keeps the bits above the wrap span
    // and lets only the low bits roll over inside the (len+1)<<size window.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [7:0]            len,
        input logic [2:0]            size,
        input logic [1:0]            burst
    );
        logic [ADDR_WIDTH-1:0] step;
        logic [ADDR_WIDTH-1:0] span;
        logic [ADDR_WIDTH-1:0] mask;
        step = ADDR_WIDTH'(1) << size;
        span = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size;
        mask = span - ADDR_WIDTH'(1);
        case (burst)
            2'b00:   next_addr = addr;
            2'b10:   next_addr = (addr & ~mask) | ((addr + step) & mask);
            default: next_addr = addr + step;
        endcase
    endfunction

    // ---------------- write channel ----------------
    w_state_t              w_state, w_next;
    logic [ID_WIDTH-1:0]   w_id;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [7:0]            w_len;
    logic [2:0]            w_size;
    logic [1:0]            w_burst;
    logic [7:0]            w_cnt;
    logic                  w_err;
    logic                  w_beat;
    logic                  w_final;
    logic                  awready_d, wready_d, bvalid_d;

    assign w_beat  = wvalid && wready;
    assign w_final = (w_cnt == w_len);

    always_ff @(posedge clk) begin
        if (!reset) w_state <= W_IDLE;
        else        w_state <= w_next;
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (awvalid && awready) w_next = W_DATA;
            W_DATA:  if (w_beat && w_final)  w_next = W_RESP;
            W_RESP:  if (bvalid && bready)   w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    // Handshake outputs are registered copies of the upcoming state.
    always_comb begin
        awready_d = (w_next == W_IDLE);
        wready_d  = (w_next == W_DATA);
        bvalid_d  = (w_next == W_RESP);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bid     <= '0;
            bresp   <= 2'b00;
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_cnt   <= '0;
            w_err   <= 1'b0;
        end else begin
            awready <= awready_d;
            wready  <= wready_d;
            bvalid  <= bvalid_d;
            if (w_state == W_IDLE && awvalid && awready) begin
                w_id    <= awid;
                w_addr  <= awaddr;
                w_len   <= awlen;
                w_size  <= awsize;
                w_burst <= awburst;
                w_cnt   <= '0;
                w_err   <= 1'b0;
            end
            if (w_state == W_DATA && w_beat) begin
                w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
                w_cnt  <= w_cnt + 8'd1;
                // The beat count ends the burst; wlast only grades the response.
                if (wlast != w_final) w_err <= 1'b1;
                if (w_final) begin
                    bid   <= w_id;
                    bresp <= (w_err || (wlast != w_final)) ? 2'b10 : 2'b00;
                end
            end
        end
    end

    // No write lands on the edge where reset is sampled low.
    always_ff @(posedge clk) begin
        if (reset && w_state == W_DATA && w_beat) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) mem[w_addr[IDX_W+1:2]][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // ---------------- read channel ----------------
    r_state_t              r_state, r_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic [7:0]            r_cnt;
    logic                  arready_d, rvalid_d;

    always_ff @(posedge clk) begin
        if (!reset) r_state <= R_IDLE;
        else        r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (arvalid && arready)        r_next = R_DATA;
            R_DATA:  if (rvalid && rready && rlast) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        arready_d = (r_next == R_IDLE);
        rvalid_d  = (r_next == R_DATA);
    end

    // r_addr/r_cnt always describe the beat to be loaded on the next
    // handshake, so consecutive beats go out back to back. Reading mem here
    // on the same edge as a write returns the pre-write contents.
    always_ff @(posedge clk) begin
        if (!reset) begin
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rid     <= '0;
            rdata   <= '0;
            rresp   <= 2'b00;
            rlast   <= 1'b0;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_cnt   <= '0;
        end else begin
            arready <= arready_d;
            rvalid  <= rvalid_d;
            rresp   <= 2'b00;
            if (r_state == R_IDLE && arvalid && arready) begin
                rid     <= arid;
                rdata   <= mem[araddr[IDX_W+1:2]];
                rlast   <= (arlen == 8'd0);
                r_addr  <= next_addr(araddr, arlen, arsize, arburst);
                r_len   <= arlen;
                r_size  <= arsize;
                r_burst <= arburst;
                r_cnt   <= 8'd1;
            end else if (r_state == R_DATA && rvalid && rready) begin
                if (rlast) begin
                    rlast <= 1'b0;
                end else begin
                    rdata  <= mem[r_addr[IDX_W+1:2]];
                    rlast  <= (r_cnt == r_len);
                    r_addr <= next_addr(r_addr, r_len, r_size, r_burst);
                    r_cnt  <= r_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_slave_mem.sv
module tb_axi_slave_mem;

    logic        clk;
    logic        reset;
    logic [7:0]  awid;
    logic [15:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [7:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [7:0]  arid;
    logic [15:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [7:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] ref_mem [1024];
    logic [31:0] wd_q [256];
    logic [3:0]  ws_q [256];

    axi_slave_mem #(
        .DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(8), .MEM_WORDS(1024)
    ) dut (
        .clk(clk), .reset(reset),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Address of beat k from the AXI burst rules, computed directly from k.
    function automatic logic [15:0] beat_addr(input logic [15:0] start, input logic [7:0] len,
                                              input logic [2:0] size, input logic [1:0] burst,
                                              input int k);
        int bytes, total, s, lower;
        bytes = 1 << size;
        total = (int'(len) + 1) * bytes;
        s     = int'(start);
        case (burst)
            2'b00: return start;
            2'b10: begin
                lower = (s / total) * total;
                return 16'(lower + ((s - lower + k * bytes) % total));
            end
            default: return 16'((s + k * bytes) % 65536);
        endcase
    endfunction

    function automatic int widx(input logic [15:0] a);
        return (int'(a) / 4) % 1024;
    endfunction

    task automatic model_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        for (int i = 0; i < 4; i++)
            if (s[i]) ref_mem[widx(a)][8*i +: 8] = d[8*i +: 8];
    endtask

    // wlast_mode: 0 correct, 1 never asserted, 2 also asserted on beat 0.
    // abort_beat >= 0 pulls reset low when that beat is about to be accepted.
    task automatic do_write(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input int wlast_mode, input int abort_beat, input bit rnd);
        int n;
        logic [15:0] a;
        bit bad;
        bad = (wlast_mode == 1) || (wlast_mode == 2 && len != 8'd0);
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        n = 0;
        while (awready !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        check("aw_wait", 32'(n < 100), 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            a = beat_addr(addr, len, size, burst, b);
            if (rnd) while ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            wdata = wd_q[b];
            wstrb = ws_q[b];
            case (wlast_mode)
                1:       wlast = 1'b0;
                2:       wlast = (b == int'(len)) || (b == 0);
                default: wlast = (b == int'(len));
            endcase
            wvalid = 1'b1;
            n = 0;
            while (wready !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
            check("w_wait", 32'(n < 100), 32'd1);
            if (b == abort_beat) begin
                reset = 1'b0;
                @(posedge clk); #1;
                check("abort_bvalid", bvalid, 0);
                check("abort_wready", wready, 0);
                check("abort_awready", awready, 0);
                reset = 1'b1;
                wvalid = 1'b0;
                wlast = 1'b0;
                @(posedge clk); #1;
                check("abort_awready_after", awready, 1);
                check("abort_arready_after", arready, 1);
                for (int i = 0; i < 3; i++) begin
                    check("abort_no_b", bvalid, 0);
                    @(posedge clk); #1;
                end
                return;
            end
            @(posedge clk); #1;
            model_write(a, wd_q[b], ws_q[b]);
            wvalid = 1'b0;
            wlast = 1'b0;
        end
        check("w_ready_low_after_last", wready, 0);
        n = 0;
        while (bvalid !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        check("b_wait", 32'(n < 100), 32'd1);
        check("b_id", bid, id);
        check("b_resp", bresp, bad ? 32'd2 : 32'd0);
        if (rnd) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
                check("b_hold", bvalid, 1);
            end
        end
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        check("b_done", bvalid, 0);
        check("aw_ready_after_b", awready, 1);
    endtask

    task automatic do_read(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input bit rnd);
        int n, k;
        bit hs, stalled;
        logic [15:0] a;
        logic [31:0] p_rdata;
        logic [7:0]  p_rid;
        logic        p_rlast;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        n = 0;
        while (arready !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        check("ar_wait", 32'(n < 100), 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        check("r_first_latency", rvalid, 1);
        k = 0; n = 0; stalled = 1'b0;
        p_rdata = '0; p_rid = '0; p_rlast = 1'b0;
        while (k <= int'(len) && n < 1000) begin
            hs = 1'b0;
            if (rvalid === 1'b1) begin
                a = beat_addr(addr, len, size, burst, k);
                if (stalled) begin
                    check("r_stall_data", rdata, p_rdata);
                    check("r_stall_id", rid, p_rid);
                    check("r_stall_last", rlast, p_rlast);
                end
                check("r_id", rid, id);
                check("r_data", rdata, ref_mem[widx(a)]);
                check("r_last", rlast, 32'(k == int'(len)));
                check("r_resp", rresp, 0);
                rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                hs = rready;
                stalled = !rready;
                p_rdata = rdata; p_rid = rid; p_rlast = rlast;
            end else begin
                rready = 1'b0;
                stalled = 1'b0;
            end
            @(posedge clk); #1;
            n++;
            if (hs) k++;
        end
        rready = 1'b0;
        check("r_beats", 32'(k), 32'(int'(len) + 1));
        check("r_idle_after_last", rvalid, 0);
    endtask

    initial begin
        logic [7:0]  id, len;
        logic [15:0] addr;
        logic [2:0]  size;
        logic [1:0]  burst;

        reset = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
        awlock = 1'b0; awcache = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
        arlock = 1'b0; arcache = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", awready, 0);
        check("rst_wready", wready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_arready", arready, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rlast", rlast, 0);
        check("rst_bid", bid, 0);
        check("rst_bresp", bresp, 0);
        check("rst_rid", rid, 0);
        check("rst_rresp", rresp, 0);
        check("rst_rdata", rdata, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rel_awready", awready, 1);
        check("rel_arready", arready, 1);

        // 4-beat INCR write then read back
        for (int b = 0; b < 4; b++) begin wd_q[b] = 32'hA0 + 32'(b); ws_q[b] = 4'hF; end
        do_write(8'd5, 16'h0010, 8'd3, 3'd2, 2'b01, 0, -1, 1'b0);
        do_read(8'd5, 16'h0010, 8'd3, 3'd2, 2'b01, 1'b0);

        // WRAP write starting mid-window, read linearly and as WRAP
        for (int b = 0; b < 4; b++) begin wd_q[b] = 32'hB0 + 32'(b); ws_q[b] = 4'hF; end
        do_write(8'd6, 16'h0018, 8'd3, 3'd2, 2'b10, 0, -1, 1'b0);
        do_read(8'd7, 16'h0010, 8'd3, 3'd2, 2'b01, 1'b0);
        do_read(8'd8, 16'h0018, 8'd3, 3'd2, 2'b10, 1'b0);

        // partial strobes
        wd_q[0] = 32'h12345678; ws_q[0] = 4'hF;
        do_write(8'd9, 16'h0040, 8'd0, 3'd2, 2'b01, 0, -1, 1'b0);
        wd_q[0] = 32'hFFFFFFFF; ws_q[0] = 4'b0011;
        do_write(8'd9, 16'h0040, 8'd0, 3'd2, 2'b01, 0, -1, 1'b0);
        do_read(8'd9, 16'h0040, 8'd0, 3'd2, 2'b01, 1'b0);
        check("strb_model", ref_mem[16], 32'h1234FFFF);

        // wlast errors
        wd_q[0] = 32'hC0C0C0C0; wd_q[1] = 32'hC1C1C1C1; ws_q[0] = 4'hF; ws_q[1] = 4'hF;
        do_write(8'd10, 16'h0080, 8'd1, 3'd2, 2'b01, 1, -1, 1'b0);
        do_read(8'd10, 16'h0080, 8'd1, 3'd2, 2'b01, 1'b0);
        for (int b = 0; b < 4; b++) begin wd_q[b] = 32'hD0 + 32'(b); ws_q[b] = 4'hF; end
        do_write(8'd11, 16'h0090, 8'd3, 3'd2, 2'b01, 2, -1, 1'b0);
        do_read(8'd11, 16'h0090, 8'd3, 3'd2, 2'b01, 1'b0);

        // INCR across the top of the address space
        for (int b = 0; b < 4; b++) begin wd_q[b] = $urandom; ws_q[b] = 4'hF; end
        do_write(8'd12, 16'hFFF8, 8'd3, 3'd2, 2'b01, 0, -1, 1'b0);
        do_read(8'd12, 16'hFFF8, 8'd3, 3'd2, 2'b01, 1'b0);

        // len=7 read with random backpressure
        for (int b = 0; b < 8; b++) begin wd_q[b] = $urandom; ws_q[b] = 4'hF; end
        do_write(8'd13, 16'h0100, 8'd7, 3'd2, 2'b01, 0, -1, 1'b1);
        do_read(8'd14, 16'h0100, 8'd7, 3'd2, 2'b01, 1'b1);

        // reset during beat 2 of a len=7 write; earlier beats must survive
        for (int b = 0; b < 8; b++) begin wd_q[b] = 32'hE0 + 32'(b); ws_q[b] = 4'hF; end
        do_write(8'd15, 16'h0200, 8'd7, 3'd2, 2'b01, 0, 2, 1'b0);
        do_read(8'd15, 16'h0200, 8'd1, 3'd2, 2'b01, 1'b0);

        // randomized bursts: full-strobe prefill, random-strobe overwrite, readback
        for (int t = 0; t < 10; t++) begin
            burst = 2'($urandom_range(0, 2));
            size  = 3'($urandom_range(0, 2));
            if (burst == 2'b10) len = 8'((1 << $urandom_range(1, 4)) - 1);
            else                len = 8'($urandom_range(0, 7));
            addr = 16'($urandom_range(0, 65535)) & ~16'((1 << size) - 1);
            id   = 8'($urandom);
            for (int b = 0; b <= int'(len); b++) begin wd_q[b] = $urandom; ws_q[b] = 4'hF; end
            do_write(id, addr, len, size, burst, 0, -1, 1'b1);
            for (int b = 0; b <= int'(len); b++) begin
                wd_q[b] = $urandom;
                ws_q[b] = 4'($urandom_range(0, 15));
            end
            do_write(id, addr, len, size, burst, 0, -1, 1'b1);
            do_read(id + 8'd1, addr, len, size, burst, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axi_slave_mem.md
AXI_SLAVE_MEM -- requirements
Module: axi_slave_mem

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, data bus width; legal values 32 only.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 16, byte address width.
REQ-003 The block SHALL have parameter ID_WIDTH, default 8, transaction ID width.
REQ-004 The block SHALL have parameter MEM_WORDS, default 1024, memory depth in 32-bit words; power of two.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset, input, 1, synchronous active-low reset.
REQ-007 The block SHALL have AW inputs awid/awaddr/awlen/awsize/awburst, widths ID_WIDTH/ADDR_WIDTH/8/3/2, write address command.
REQ-008 The block SHALL have awvalid input 1, awready output 1, AW handshake.
REQ-009 The block SHALL have W inputs wdata DATA_WIDTH, wstrb DATA_WIDTH/8, wlast 1, wvalid 1, and wready output 1.
REQ-010 The block SHALL have B outputs bid ID_WIDTH, bresp 2, bvalid 1, and bready input 1.
REQ-011 The block SHALL have AR inputs arid/araddr/arlen/arsize/arburst, same widths as AW, plus arvalid input 1 and arready output 1.
REQ-012 The block SHALL have R outputs rid ID_WIDTH, rdata DATA_WIDTH, rresp 2, rlast 1, rvalid 1, and rready input 1.
REQ-013 The block SHALL accept and ignore the inputs awlock, awcache, awprot, arlock, arcache and arprot (widths 1/4/3).

Function
REQ-014 Write and read paths SHALL be independent; each path SHALL allow one outstanding burst.
REQ-015 Write FSM SHALL have three states: W_IDLE (awready=1), W_DATA (wready=1) and W_RESP (bvalid=1).
REQ-016 On an AW handshake (awvalid&awready) in W_IDLE the block SHALL capture id/addr/len/size/burst, clear the beat counter and enter W_DATA next cycle.
REQ-017 Each W handshake SHALL write the strobed bytes of wdata to mem[(addr>>2) mod MEM_WORDS]; bytes with wstrb=0 SHALL be unchanged.
REQ-018 After beat awlen+1 the block SHALL enter W_RESP, drive bid=captured awid, and hold bvalid until bready.
REQ-019 bresp SHALL be 2'b00 (OKAY), or 2'b10 (SLVERR) if wlast mismatched on any beat (high before the final beat, or low on it); the beat count alone SHALL end the burst.
REQ-020 On a B handshake the write FSM SHALL return to W_IDLE, so the next AW is accepted no earlier than the following cycle.
REQ-021 Read FSM SHALL have two states: R_IDLE (arready=1) and R_DATA (rvalid=1).
REQ-022 On an AR handshake the block SHALL capture the command and present beat 0 with rvalid=1 on the next cycle.
REQ-023 In R_DATA, rdata SHALL be a register holding mem[current addr]; rid=captured arid; rresp=2'b00; rlast=1 only on beat arlen.
REQ-024 rvalid and all R fields SHALL stay stable while rready=0; each R handshake SHALL load the next beat in the same edge, with no bubble.
REQ-025 After the rlast handshake the read FSM SHALL return to R_IDLE.
REQ-026 Beat address update for FIXED (00) SHALL leave addr unchanged.
REQ-027 Beat address update for INCR (01) and reserved (11) SHALL be addr += 1<<size, modulo 2^ADDR_WIDTH.
REQ-028 Beat address update for WRAP (10) SHALL be addr += 1<<size, wrapping to the boundary aligned to (len+1)<<size; len is limited to 1/3/7/15.
REQ-029 Word index SHALL wrap modulo MEM_WORDS, and no address SHALL produce an error response.
REQ-030 A same-cycle read and write to the same word SHALL return the old data on R.
REQ-031 Each AXI output SHALL be driven directly from a register.

Reset
REQ-032 While reset=0 at a clock edge, awready, wready, bvalid, arready, rvalid and rlast SHALL be 0.
REQ-033 While reset=0 at a clock edge, bid, bresp, rid, rresp and rdata SHALL be 0, and both FSMs SHALL go to their IDLE state.
REQ-034 The cycle after reset deasserts, awready and arready SHALL be 1.
REQ-035 Reset mid-burst SHALL abort both bursts with no B or R completion; beats already written SHALL remain in memory.
REQ-036 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-037 The bench SHALL check: AW id=5 addr=0x0010 len=3 size=2 INCR, W 4 beats 0xA0..0xA3 wstrb=F -> B id=5 OKAY; AR same -> 4 R beats 0xA0..0xA3, rlast on beat 3 only.
REQ-038 The bench SHALL check: WRAP len=3 size=2 starting at addr 0x0018 -> beats written to 0x18, 0x1C, 0x10, 0x14.
REQ-039 The bench SHALL check: wstrb=4'b0011 with wdata 0xFFFFFFFF over 0x12345678 -> readback 0x1234FFFF.
REQ-040 The bench SHALL check: wlast low on the final beat of a len=1 burst -> bresp=2'b10, and data still written.
REQ-041 The bench SHALL check: rready toggled randomly during a len=7 read -> rdata/rid/rlast stable while stalled, and no beat lost or duplicated.
REQ-042 The bench SHALL check: reset=0 asserted on beat 2 of a len=7 write -> no bvalid, and awready=1 the cycle after reset releases.
